// File: rtl/caravel_reset_seq.sv
// Power-on reset sequencer: releases NUM_DOM active-low domain resets in order,
// then services per-domain soft-reset requests (lowest index first).
//
// state   | meaning
// ASSERT  | all domains held in reset, waiting for resetb_sync
// WAIT    | counting down the inter-domain gap
// RELEASE | releasing domain idx at the end of this cycle
// DONE    | all domains released, idle or picking the next soft request
// SOFT    | holding one domain in reset for hold_cycles+1 cycles
module caravel_reset_seq #(
    parameter int NUM_DOM = 4,
    parameter int DLY_W   = 8
) (
    input  logic               ext_clk,
    input  logic               reset,
    input  logic               resetb_sync,
    input  logic [DLY_W-1:0]   stage_delay,
    input  logic [DLY_W-1:0]   hold_cycles,
    input  logic [NUM_DOM-1:0] soft_rst_req,
    output logic [NUM_DOM-1:0] rst_n_dom,
    output logic [NUM_DOM-1:0] soft_rst_ack,
    output logic               seq_busy,
    output logic               seq_done
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOM - 1);

    typedef enum logic [2:0] {
        ST_ASSERT  = 3'd0,
        ST_WAIT    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_DONE    = 3'd3,
        ST_SOFT    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DLY_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   sidx_q, sidx_d;
    logic [NUM_DOM-1:0] pend_q, pend_d;
    logic [NUM_DOM-1:0] rst_n_q, rst_n_d;
    logic [NUM_DOM-1:0] ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [NUM_DOM-1:0] pend_eff;
    logic [IDX_W-1:0]   low_idx;
    logic               low_vld;

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            sidx_q  <= '0;
            pend_q  <= '0;
            rst_n_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sidx_q  <= sidx_d;
            pend_q  <= pend_d;
            rst_n_q <= rst_n_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Requests seen this cycle are eligible immediately, so DONE never drops one.
    always_comb begin
        pend_eff = pend_q | soft_rst_req;
        low_idx  = '0;
        low_vld  = 1'b0;
        for (int k = NUM_DOM - 1; k >= 0; k--) begin
            if (pend_eff[k]) begin
                low_idx = IDX_W'(k);
                low_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sidx_d  = sidx_q;
        pend_d  = pend_eff;
        if (!resetb_sync) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            pend_d  = '0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    idx_d = '0;
                    if (stage_delay == '0) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = stage_delay;
                    end
                end
                // The RELEASE cycle is the last of each stage_delay+1 interval.
                ST_WAIT: begin
                    if (cnt_q <= DLY_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q - DLY_W'(1);
                    end
                end
                ST_RELEASE: begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else if (stage_delay == '0) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = stage_delay;
                    end
                end
                ST_DONE: begin
                    if (low_vld) begin
                        state_d         = ST_SOFT;
                        sidx_d          = low_idx;
                        pend_d[low_idx] = 1'b0;
                        cnt_d           = hold_cycles;
                    end
                end
                ST_SOFT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - DLY_W'(1);
                    end
                end
                default: state_d = ST_ASSERT;
            endcase
        end
    end

    always_comb begin
        rst_n_d = rst_n_q;
        ack_d   = '0;
        if (!resetb_sync) begin
            rst_n_d = '0;
        end else begin
            case (state_q)
                ST_ASSERT:  rst_n_d = '0;
                ST_RELEASE: rst_n_d[idx_q] = 1'b1;
                ST_DONE: begin
                    if (state_d == ST_SOFT) rst_n_d[low_idx] = 1'b0;
                end
                ST_SOFT: begin
                    if (state_d == ST_DONE) begin
                        rst_n_d[sidx_q] = 1'b1;
                        ack_d[sidx_q]   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d == ST_ASSERT) || (state_d == ST_WAIT) || (state_d == ST_SOFT);
        done_d = (state_d == ST_DONE);
    end

    assign rst_n_dom    = rst_n_q;
    assign soft_rst_ack = ack_q;
    assign seq_busy     = busy_q;
    assign seq_done     = done_q;

endmodule

// File: tb/tb_caravel_reset_seq.sv
// Bench for caravel_reset_seq: directed scenarios plus randomized delay/hold/request
// trials checked against an arithmetic timeline model.
module tb_caravel_reset_seq;

    localparam int ND = 4;
    localparam int DW = 8;
    localparam logic [ND-1:0] ALL = '1;

    logic          ext_clk = 1'b0;
    logic          reset;
    logic          resetb_sync;
    logic [DW-1:0] stage_delay;
    logic [DW-1:0] hold_cycles;
    logic [ND-1:0] soft_rst_req;
    logic [ND-1:0] rst_n_dom;
    logic [ND-1:0] soft_rst_ack;
    logic          seq_busy;
    logic          seq_done;

    int errs   = 0;
    int checks = 0;
    int svc_q[$];

    caravel_reset_seq #(.NUM_DOM(ND), .DLY_W(DW)) dut (
        .ext_clk      (ext_clk),
        .reset        (reset),
        .resetb_sync  (resetb_sync),
        .stage_delay  (stage_delay),
        .hold_cycles  (hold_cycles),
        .soft_rst_req (soft_rst_req),
        .rst_n_dom    (rst_n_dom),
        .soft_rst_ack (soft_rst_ack),
        .seq_busy     (seq_busy),
        .seq_done     (seq_done)
    );

    always #5 ext_clk = ~ext_clk;

    task automatic tick();
        @(posedge ext_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [ND-1:0] e_rst, input logic [ND-1:0] e_ack,
                            input logic e_busy, input logic e_done);
        chk({tag, "_rst_n"}, 32'(rst_n_dom), 32'(e_rst));
        chk({tag, "_ack"},   32'(soft_rst_ack), 32'(e_ack));
        chk({tag, "_busy"},  32'(seq_busy), 32'(e_busy));
        chk({tag, "_done"},  32'(seq_done), 32'(e_done));
    endtask

    // Edge 0 is the first edge that samples resetb_sync=1 in ASSERT. Domain k rises
    // (k+1)*(D+1) edges later; the cycle just before each rise is neither busy nor done.
    task automatic run_seq(input string tag, input int d);
        int p, last, n;
        logic rel, dn;
        p    = d + 1;
        last = ND * p;
        for (int t = 0; t <= last + 1; t++) begin
            tick();
            n = t / p;
            if (n > ND) n = ND;
            dn  = (t >= last);
            rel = (((t + 1) % p) == 0) && ((t + 1) <= last);
            chk_outs(tag, ND'((1 << n) - 1), '0, !dn && !rel, dn);
        end
    endtask

    task automatic power_up(input string tag, input int d);
        reset        = 1'b1;
        resetb_sync  = 1'b1;
        soft_rst_req = '0;
        tick();
        tick();
        chk_outs({tag, "_rstval"}, '0, '0, 1'b1, 1'b0);
        stage_delay = DW'(d);
        reset       = 1'b0;
        run_seq(tag, d);
    endtask

    // Starting in DONE: services in svc_q order, each one H+1 cycles low then a one-cycle ack.
    task automatic soft_seq(input string tag, input int h, input logic [ND-1:0] mask,
                            input logic [ND-1:0] mask2, input int r2);
        int n, per, j, ph;
        n   = svc_q.size();
        per = h + 2;
        hold_cycles  = DW'(h);
        soft_rst_req = mask;
        for (int r = 0; r <= n * per + 1; r++) begin
            tick();
            soft_rst_req = (r == r2) ? mask2 : '0;
            j  = r / per;
            ph = r % per;
            if (j < n && ph <= h)
                chk_outs(tag, ALL & ~ND'(1 << svc_q[j]), '0, 1'b1, 1'b0);
            else if (j < n)
                chk_outs(tag, ALL, ND'(1 << svc_q[j]), 1'b0, 1'b1);
            else
                chk_outs(tag, ALL, '0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        int d, h;
        logic [ND-1:0] m;
        reset        = 1'b1;
        resetb_sync  = 1'b0;
        stage_delay  = '0;
        hold_cycles  = '0;
        soft_rst_req = '0;

        // Power-up with delay 3 and with delay 0
        power_up("pwr_d3", 3);
        power_up("pwr_d0", 0);

        // Single soft reset on domain 2, hold 2
        svc_q = '{2};
        soft_seq("soft_d2", 2, 4'b0100, '0, -1);

        // Simultaneous requests 1010
        svc_q = '{1, 3};
        soft_seq("soft_1010", 1, 4'b1010, '0, -1);

        // Re-request of the domain currently in SOFT
        svc_q = '{1, 1};
        soft_seq("soft_rereq", 3, 4'b0010, 4'b0010, 1);

        // Abort during SOFT on domain 0 with domain 2 pending
        hold_cycles  = DW'(5);
        soft_rst_req = 4'b0001;
        tick();
        soft_rst_req = 4'b0100;
        chk_outs("abort_soft", 4'b1110, '0, 1'b1, 1'b0);
        tick();
        soft_rst_req = '0;
        chk_outs("abort_soft2", 4'b1110, '0, 1'b1, 1'b0);
        resetb_sync = 1'b0;
        tick();
        chk_outs("abort_now", '0, '0, 1'b1, 1'b0);
        tick();
        chk_outs("abort_hold", '0, '0, 1'b1, 1'b0);
        stage_delay = DW'(1);
        resetb_sync = 1'b1;
        run_seq("abort_rerun", 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_outs("abort_nopend", ALL, '0, 1'b0, 1'b1);
        end

        // Block reset after domain 1 released
        reset = 1'b1;
        tick();
        tick();
        stage_delay = DW'(2);
        reset       = 1'b0;
        for (int t = 0; t <= 6; t++) tick();
        chk_outs("midrst_pre", 4'b0011, '0, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        chk_outs("midrst_val", '0, '0, 1'b1, 1'b0);
        reset = 1'b0;
        run_seq("midrst_rerun", 2);

        // Randomized trials
        for (int trial = 0; trial < 6; trial++) begin
            d = int'($urandom_range(0, 4));
            h = int'($urandom_range(0, 3));
            m = ND'($urandom_range(1, 15));
            power_up("rnd_pwr", d);
            svc_q.delete();
            for (int k = 0; k < ND; k++) if (m[k]) svc_q.push_back(k);
            soft_seq("rnd_soft", h, m, '0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/caravel_reset_seq.md
CARAVEL_RESET_SEQ -- requirements
Module: caravel_reset_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The clock port SHALL be `ext_clk`, and the reset port SHALL be `reset`.
REQ-003 Parameter NUM_DOM, default 4: number of reset domains sequenced.
REQ-004 Parameter DLY_W, default 8: width of the delay and hold configuration fields.
REQ-005 Port `ext_clk`, input, 1: block clock; all state updates on the rising edge.
REQ-006 Port `reset`, input, 1: synchronous active-high block reset.
REQ-007 Port `resetb_sync`, input, 1: buffered active-low chip reset from the clocking stage; low means re-sequence.
REQ-008 Port `stage_delay`, input, DLY_W: cycles between successive domain releases.
REQ-009 Port `hold_cycles`, input, DLY_W: soft-reset assertion length.
REQ-010 Port `soft_rst_req`, input, NUM_DOM: one-cycle soft-reset request strobes, one per domain.
REQ-011 Port `rst_n_dom`, output, NUM_DOM: per-domain active-low resets; bit 0 is released first.
REQ-012 Port `soft_rst_ack`, output, NUM_DOM: one-cycle acknowledge per domain.
REQ-013 Port `seq_busy`, output, 1: high while the block is in ASSERT, WAIT or SOFT.
REQ-014 Port `seq_done`, output, 1: high only in DONE.

Function
REQ-015 The FSM SHALL have exactly five states: ASSERT, WAIT, RELEASE, DONE, SOFT.
REQ-016 ASSERT: all `rst_n_dom` SHALL be 0 and the domain index SHALL be 0.
REQ-017 ASSERT -> WAIT SHALL occur when `resetb_sync` is sampled 1, loading the counter with `stage_delay`.
REQ-018 WAIT SHALL decrement the counter each cycle and go to RELEASE on the cycle the counter equals 0.
REQ-019 RELEASE SHALL set `rst_n_dom[idx]` to 1 and increment idx.
REQ-020 RELEASE SHALL go to DONE if idx was NUM_DOM-1; otherwise it SHALL go to WAIT, reloading the counter with `stage_delay`.
REQ-021 Timing: each `rst_n_dom[k]` SHALL rise exactly `stage_delay`+1 cycles after the previous event (the first `resetb_sync`=1 sample in ASSERT, or the release of domain k-1).
REQ-022 `stage_delay`=0 SHALL be legal and SHALL release domains on consecutive cycles.
REQ-023 `stage_delay` SHALL be sampled only at counter load; changes during WAIT SHALL have no effect on the current interval.
REQ-024 Released domains SHALL stay 1 until ASSERT is re-entered or that domain's own soft reset occurs.
REQ-025 Each `soft_rst_req[i]` pulse SHALL set pending bit i; the bit SHALL be held until serviced.
REQ-026 Requests arriving in any state other than DONE SHALL be latched, not dropped; duplicate requests to a pending bit SHALL merge into one.
REQ-027 In DONE with any pending bit set, the block SHALL enter SOFT for the lowest pending index i.
REQ-028 On entering SOFT the block SHALL clear bit i, drive `rst_n_dom[i]`=0 and load the counter with `hold_cycles`.
REQ-029 SOFT SHALL hold `rst_n_dom[i]` at 0 for exactly `hold_cycles`+1 cycles.
REQ-030 On the following cycle `rst_n_dom[i]` SHALL return to 1 and `soft_rst_ack[i]` SHALL pulse for one cycle, with the FSM in DONE.
REQ-031 The next pending request SHALL be serviced from the cycle after that return to DONE.
REQ-032 A soft reset SHALL affect only domain i; other domains SHALL be unaffected.
REQ-033 A request for domain i arriving while domain i is in SOFT SHALL set pending bit i again and be serviced afterwards.
REQ-034 `resetb_sync` sampled 0 in any state SHALL force ASSERT on the next cycle.
REQ-035 On that abort all `rst_n_dom` SHALL be 0, pending bits SHALL be cleared and no ack SHALL be issued.
REQ-036 `resetb_sync` low SHALL take priority over soft requests and counter expiry in the same cycle.
REQ-037 Outputs SHALL be registered; `seq_busy` and `seq_done` SHALL be mutually exclusive.

Reset
REQ-038 While `reset`=1: state SHALL be ASSERT, `rst_n_dom`=0, `soft_rst_ack`=0, `seq_busy`=1, `seq_done`=0, counter=0, idx=0, pending=0.
REQ-039 `reset` SHALL take priority over every other input, including mid-sequence and mid-SOFT.
REQ-040 Sequencing SHALL restart from domain 0 after `reset` deasserts.

Verification
REQ-041 Power-up: `stage_delay`=3 and `resetb_sync`=1 from the first post-reset cycle -> `rst_n_dom` becomes 0001, 0011, 0111, 1111 at cycles 4, 8, 12, 16; `seq_done`=1 at cycle 16.
REQ-042 Zero delay: `stage_delay`=0 -> domains release on 4 consecutive cycles starting cycle 1.
REQ-043 Soft reset: in DONE, `hold_cycles`=2 and `soft_rst_req`=0100 -> `rst_n_dom[2]`=0 for 3 cycles; then `soft_rst_ack`=0100 for one cycle and `rst_n_dom`=1111.
REQ-044 Simultaneous requests: `soft_rst_req`=1010 in one cycle -> domain 1 is serviced first, then domain 3, with acks 0010 then 1000.
REQ-045 Abort: `resetb_sync` driven 0 during SOFT on domain 0 with a pending request for domain 2 -> next cycle `rst_n_dom`=0000, no ack, pending cleared, and the sequence reruns when `resetb_sync`=1.
REQ-046 Mid-sequence reset: `reset`=1 after domain 1 is released -> all outputs take their reset values next cycle; the sequence restarts from domain 0.
